spi_slave_port: RTL
===================

Name: spi_slave_port

Overview:
- Word-oriented SPI slave sitting directly downstream of the CPU's SPI master pins: sclk, cs, MOSI out, MISO in.
- Deserialises MOSI into W-bit words and hands them to a consumer over a valid/ready handshake.
- Serialises a W-bit response word, accepted over a valid/ready handshake, onto MISO.
- Runs entirely in the clk domain; sclk and cs are treated as asynchronous inputs and oversampled.

Parameters:
W, 32, word width in bits (CPU word width)
IDLE_WORD, 32'h0000_0000, word shifted out when no tx word is loaded at frame/word start

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from master, async
cs  input  1  chip select from master, active-high, async
mosi  input  1  master-out data, async
miso  output  1  master-in data
tx_data  input  W  response word
tx_valid  input  1  tx_data valid
tx_ready  output  1  tx holding register empty
rx_data  output  W  received word
rx_valid  output  1  rx_data valid
rx_ready  input  1  consumer accepts rx_data
overrun  output  1  sticky: word received while rx_valid still set
frame_err  output  1  one-cycle pulse: cs dropped mid-word
busy  output  1  state != IDLE

Behaviour:
- Reset (rst low, async): all registers cleared.
  - Outputs: miso=0, tx_ready=1, rx_valid=0, rx_data=0, overrun=0, frame_err=0, busy=0.
  - State=IDLE; bit counter=0.
- Input sync: sclk, cs and mosi each pass through a 2-flop synchroniser. Edges are detected against a third registered copy.
  - Edge detect fires 3 clk after the pin changes.
  - clk must be at least 8x sclk.
- SPI mode 0, MSB first: sample mosi on sclk rise; update miso on sclk fall.
- TX holding register: tx_valid && tx_ready loads it and clears tx_ready.
- State IDLE:
  - On cs rise -> LOAD.
  - miso held 0.
- State LOAD (1 cycle):
  - If the tx holding register is full, shift_tx = holding register and tx_ready returns to 1; else shift_tx = IDLE_WORD.
  - miso = shift_tx[W-1]; bit counter = 0.
  - -> SHIFT.
- State SHIFT:
  - sclk rise: shift_rx = {shift_rx[W-2:0], mosi_sync}; counter++.
  - sclk fall: if counter != 0, shift_tx <<= 1 and miso = new shift_tx[W-1].
  - When counter reaches W after a rise -> DONE.
- State DONE (1 cycle):
  - rx_data = shift_rx, rx_valid = 1. If rx_valid was already 1 and not consumed this cycle, overrun sets and the old word is overwritten.
  - If cs is still high -> LOAD; back-to-back words with no gap. LOAD reloads before the next sclk fall.
  - Else -> IDLE.
- cs fall while in SHIFT with 0 < counter < W:
  - frame_err pulses 1 cycle; partial word discarded; -> IDLE.
  - rx_valid is unaffected.
- cs fall with counter=0: silent return to IDLE.
- rx handshake: rx_valid && rx_ready clears rx_valid the next cycle.
  - If DONE coincides with rx_ready, the new word is presented and rx_valid stays 1; no overrun.
- overrun clears only on reset.
- tx_valid in the same cycle as LOAD consumes the holding register: the new word is accepted only after tx_ready=1, and is used for the next word.
- Reset mid-frame: immediate return to reset values. The remainder of the frame is ignored until cs is seen low and then rises again.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: in LOAD with an empty tx holding register, shift_tx is the last word presented on rx_data (IDLE_WORD before the first word is received); the master reads back its previous word.
- Undefined: an empty holding register always yields IDLE_WORD.
- Handshake and timing are identical in both cases.

Test Plan:
- Reset: hold rst=0 with sclk toggling and cs=1 -> all outputs at reset values, no rx_valid; release -> busy=0 until the next cs rise.
- Single word: tx_data=32'hA5A5_0F0F loaded, then master sends 32'h1234_5678 over one cs frame.
  - rx_data=32'h1234_5678 and rx_valid=1 within 4 clk of the 32nd sclk rise.
  - Master captures 32'hA5A5_0F0F on MISO; tx_ready=1 after LOAD.
- Back-to-back: one cs frame carries 32'hDEAD_BEEF then 32'hCAFE_F00D; consumer holds rx_ready=0.
  - First word appears, then overrun=1 and rx_data=32'hCAFE_F00D.
  - Second MISO word = IDLE_WORD (0), or 32'hDEAD_BEEF with SPI_LOOPBACK_EN.
- Aborted frame: cs drops after 13 bits -> frame_err pulses exactly 1 clk, rx_valid stays 0, busy=0; the next full frame of 32'h0000_0001 is received correctly.
- Simultaneous consume: rx_ready=1 held continuously across two back-to-back words -> each word is presented for at least 1 cycle and overrun stays 0.
- Async reset mid-SHIFT after 20 bits -> outputs reset immediately; the following cs frame of 32'hFFFF_FFFF is received intact.

Source files
------------

// File: rtl/spi_slave_port.sv
// spi_slave_port: word-oriented SPI mode-0 slave, oversampled in clk.
// Optional SPI_LOOPBACK_EN: empty tx holding reg echoes last rx word.
module spi_slave_port #(
  parameter int             W         = 32,
  parameter logic [W-1:0]   IDLE_WORD = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sclk,
  input  logic         cs,
  input  logic         mosi,
  output logic         miso,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [W-1:0] rx_data,
  output logic         rx_valid,
  input  logic         rx_ready,
  output logic         overrun,
  output logic         frame_err,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     sclk_q, cs_q;
  logic [1:0]     mosi_q, live_q;
  logic           cs_armed;
  logic           sclk_rise, sclk_fall, cs_rise;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   shift_rx, shift_tx;
  logic [W-1:0]   hold_data, ld_word;
  logic           hold_full;
  logic           ld, rise_en, fall_en, abort, fin;
`ifdef SPI_LOOPBACK_EN
  logic           rx_seen;
`endif

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2] & cs_armed;
  assign tx_ready  = ~hold_full;
  assign busy      = (state_q != IDLE);

  // Synchronise pins; a frame is only armed once cs is seen low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q   <= '0;
      cs_q     <= '0;
      mosi_q   <= '0;
      live_q   <= '0;
      cs_armed <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs};
      mosi_q <= {mosi_q[0], mosi};
      live_q <= {live_q[0], 1'b1};
      if (live_q[1] && !cs_q[1])
        cs_armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    rise_en = 1'b0;
    fall_en = 1'b0;
    abort   = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: if (cs_rise) state_d = LOAD;
      LOAD: begin
        ld      = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (!cs_q[1]) begin
          abort   = (cnt != '0);
          state_d = IDLE;
        end else if (sclk_rise) begin
          rise_en = 1'b1;
          if (cnt == CW'(W - 1))
            state_d = DONE;
        end else if (sclk_fall && cnt != '0) begin
          fall_en = 1'b1;
        end
      end
      DONE: begin
        fin     = 1'b1;
        state_d = cs_q[1] ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word presented to the master at LOAD.
  always_comb begin
    ld_word = IDLE_WORD;
    if (hold_full)
      ld_word = hold_data;
`ifdef SPI_LOOPBACK_EN
    else if (rx_seen)
      ld_word = rx_data;
`endif
  end

  // Shift registers, bit counter and miso.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_rx  <= '0;
      shift_tx  <= '0;
      cnt       <= '0;
      miso      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= abort;
      if (ld) begin
        shift_tx <= ld_word;
        miso     <= ld_word[W-1];
        cnt      <= '0;
      end
      if (rise_en) begin
        shift_rx <= {shift_rx[W-2:0], mosi_q[1]};
        cnt      <= cnt + CW'(1);
      end
      if (fall_en) begin
        shift_tx <= shift_tx << 1;
        miso     <= shift_tx[W-2];
      end
      if (state_d == IDLE) begin
        miso <= 1'b0;
        cnt  <= '0;
      end
    end
  end

  // Receive handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (fin) begin
      rx_data  <= shift_rx;
      rx_valid <= 1'b1;
      if (rx_valid && !rx_ready)
        overrun <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef SPI_LOOPBACK_EN
  // Remembers that rx_data holds a real received word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     rx_seen <= 1'b0;
    else if (fin) rx_seen <= 1'b1;
  end
`endif

  // Transmit holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (ld && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

endmodule
